// File: rtl/branch_resolver_pkg.sv
// Shared types for the branch resolver: command encoding, result record and sizing.
// CLEAR/SQUASH encodings are shared with the branch stack and must stay fixed.
package branch_resolver_pkg;

    localparam int unsigned BRANCH_PRED_SZ = 4;
    localparam int unsigned N_WAY          = 2;
    localparam int unsigned ADDR_W         = 32;

    typedef logic [BRANCH_PRED_SZ-1:0] br_mask_t;
    typedef logic [ADDR_W-1:0]         addr_t;

    typedef enum logic [1:0] {
        NOTHING = 2'd0,
        CLEAR   = 2'd1,
        SQUASH  = 2'd2
    } br_task_e;

    typedef struct packed {
        logic     valid;
        br_mask_t b_id;
        br_mask_t b_mask;
        logic     mispredict;
        addr_t    target_pc;
    } br_result_t;

endpackage

// File: rtl/branch_resolver_psel_gen.sv
// Priority selector: grants up to REQS requests, lowest index first, one WIDTH-bit
// one-hot grant vector per request slot.
module psel_gen #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned REQS  = 1
) (
    input  logic [WIDTH-1:0]      req,
    output logic [REQS*WIDTH-1:0] gnt
);

    logic [WIDTH-1:0] remaining;
    logic [WIDTH-1:0] pick;

    always_comb begin
        gnt       = '0;
        remaining = req;
        pick      = '0;
        for (int unsigned r = 0; r < REQS; r++) begin
            // Isolate the lowest set bit, then retire it for the next grant.
            pick                      = remaining & (~remaining + WIDTH'(1));
            gnt[r*WIDTH +: WIDTH]     = pick;
            remaining                 = remaining & ~pick;
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Buffers resolved branch results per b_id and issues one registered CLEAR/SQUASH
// command per cycle to the branch stack, oldest mispredict first.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int unsigned DEPTH = BRANCH_PRED_SZ,
    parameter int unsigned N     = N_WAY
) (
    input  logic                 clock,
    input  logic                 reset,
    input  br_result_t [N-1:0]   br_res_in,
    output br_task_e             br_task,
    output br_mask_t             rem_b_id,
    output addr_t                redirect_pc,
    output logic [DEPTH-1:0]     pending
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] mp_q, mp_d;
    br_mask_t         mask_q [DEPTH];
    br_mask_t         mask_d [DEPTH];
    addr_t            pc_q   [DEPTH];
    addr_t            pc_d   [DEPTH];
    br_task_e         task_q, task_d;
    br_mask_t         rem_q, rem_d;
    addr_t            rpc_q, rpc_d;

    logic [DEPTH-1:0] mp_set;
    logic [DEPTH-1:0] sq_id;
    addr_t            sq_pc;
    logic [DEPTH-1:0] clr_id;
    logic [DEPTH-1:0] kill;
    logic [DEPTH-1:0] clr;
    logic [DEPTH-1:0] freed;
    logic [DEPTH-1:0] wr_vec;

    psel_gen #(
        .WIDTH (DEPTH),
        .REQS  (1)
    ) u_clear_pick (
        .req (valid_q),
        .gnt (clr_id)
    );

    always_comb begin
        mp_set = valid_q & mp_q;
        sq_id  = '0;
        sq_pc  = '0;
        // Oldest mispredict: no other outstanding mispredict appears in its b_mask.
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (mp_set[k] && ((mask_q[k] & mp_set) == '0) && (sq_id == '0)) begin
                sq_id[k] = 1'b1;
                sq_pc    = pc_q[k];
            end
        end

        valid_d = valid_q;
        mp_d    = mp_q;
        mask_d  = mask_q;
        pc_d    = pc_q;
        task_d  = NOTHING;
        rem_d   = '0;
        rpc_d   = '0;
        kill    = '0;
        clr     = '0;

        if (mp_set != '0) begin
            task_d = SQUASH;
            rem_d  = sq_id;
            rpc_d  = sq_pc;
            kill   = sq_id;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (sq_id[k] || ((mask_q[k] & sq_id) != '0)) begin
                    valid_d[k] = 1'b0;
                end
            end
        end else if (valid_q != '0) begin
            task_d  = CLEAR;
            rem_d   = clr_id;
            clr     = clr_id;
            valid_d = valid_q & ~clr_id;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                mask_d[k] = mask_q[k] & ~clr_id;
            end
        end

        freed  = valid_q & ~valid_d;
        wr_vec = '0;

        // Inputs are applied last so a write to a slot freed this cycle wins.
        for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (br_res_in[i].valid && br_res_in[i].b_id[k] &&
                    ((br_res_in[i].b_mask & kill) == '0)) begin
                    wr_vec[k]  = 1'b1;
                    valid_d[k] = 1'b1;
                    mp_d[k]    = br_res_in[i].mispredict;
                    mask_d[k]  = br_res_in[i].b_mask & ~clr;
                    pc_d[k]    = br_res_in[i].target_pc;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            mp_q    <= '0;
            mask_q  <= '{default: '0};
            pc_q    <= '{default: '0};
            task_q  <= NOTHING;
            rem_q   <= '0;
            rpc_q   <= '0;
        end else begin
            valid_q <= valid_d;
            mp_q    <= mp_d;
            mask_q  <= mask_d;
            pc_q    <= pc_d;
            task_q  <= task_d;
            rem_q   <= rem_d;
            rpc_q   <= rpc_d;
        end
    end

    a_no_overwrite: assert property (@(posedge clock) disable iff (!reset)
        (wr_vec & valid_q & ~freed) == '0);

    assign br_task     = task_q;
    assign rem_b_id    = rem_q;
    assign redirect_pc = rpc_q;
    assign pending     = valid_q;

endmodule
